bcd_scan_display: RTL and testbench

- Downstream consumer of the cascaded BCD digit counters: takes four BCD digit values and drives a 4-digit, active-low, time-multiplexed seven-segment display.
- Latches a coherent snapshot of all digits once per scan frame, so counter carries never tear the display.
- Provides leading-zero blanking, per-digit blink (for time-setting mode) and per-digit decimal points.

---
 rtl/bcd_scan_display_if.sv | 27 ++
 rtl/bcd_scan_display.sv | 126 ++++++++++++
 tb/tb_bcd_scan_display.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bcd_scan_display_if.sv
// ----------------------------------------------------------------------------
// bcd_scan_display_if : digit/control inputs and multiplexed 7-seg outputs
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface bcd_scan_display_if;
  logic [15:0] digits;
  logic        blank_lz;
  logic [3:0]  blink_mask;
  logic [3:0]  dp_mask;
  logic [3:0]  ssd_ctl;
  logic [7:0]  ssd_out;
  logic        frame_start;

  modport master (
    output digits, blank_lz, blink_mask, dp_mask,
    input  ssd_ctl, ssd_out, frame_start
  );

  modport slave (
    input  digits, blank_lz, blink_mask, dp_mask,
    output ssd_ctl, ssd_out, frame_start
  );
endinterface

`default_nettype wire

// File: rtl/bcd_scan_display.sv
// ----------------------------------------------------------------------------
// bcd_scan_display : 4-digit active-low multiplexed 7-seg driver with
// per-frame snapshot, leading-zero blanking, blink and decimal points.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bcd_scan_display #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  wire logic          clk,
  input  wire logic          rst,
  bcd_scan_display_if.slave  bus
);

  localparam int              c_PW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_PW-1:0] c_PS_MAX = c_PW'(SCAN_DIV - 1);
  localparam logic [9:0]      c_BF_MAX = 10'(BLINK_FRAMES - 1);

  logic [c_PW-1:0] r_prescale;
  logic [1:0]      r_idx;
  logic [9:0]      r_frame_cnt;
  logic            r_blink_phase;
  logic            r_load_pending;
  logic [15:0]     r_sh_digits;
  logic            r_sh_blank_lz;
  logic [3:0]      r_sh_blink;
  logic [3:0]      r_sh_dp;
  logic [3:0]      r_ssd_ctl;
  logic [7:0]      r_ssd_out;
  logic            r_frame_start;

  logic            w_tick;
  logic            w_wrap;
  logic            w_load;
  logic [3:0]      w_digit;
  logic [3:0]      w_zero;
  logic [3:0]      w_lz;
  logic [7:0]      w_seg;
  logic [7:0]      w_out;

  always_comb begin
    w_tick  = (r_prescale == c_PS_MAX);
    w_wrap  = w_tick && (r_idx == 2'd3);
    w_load  = w_wrap || r_load_pending;
    w_digit = r_sh_digits[{r_idx, 2'b00} +: 4];
    for (int k = 0; k < 4; k++) begin
      w_zero[k] = (r_sh_digits[4*k +: 4] == 4'd0);
    end
    // Digit k is a leading zero when it and every higher digit are zero
    w_lz = {w_zero[3],
            w_zero[3] & w_zero[2],
            w_zero[3] & w_zero[2] & w_zero[1],
            1'b0};

    case (w_digit)
      4'd0:    w_seg = 8'h03;
      4'd1:    w_seg = 8'h9F;
      4'd2:    w_seg = 8'h25;
      4'd3:    w_seg = 8'h0D;
      4'd4:    w_seg = 8'h99;
      4'd5:    w_seg = 8'h49;
      4'd6:    w_seg = 8'h41;
      4'd7:    w_seg = 8'h1F;
      4'd8:    w_seg = 8'h01;
      4'd9:    w_seg = 8'h09;
      default: w_seg = 8'hFD;
    endcase

    if (r_blink_phase && r_sh_blink[r_idx]) begin
      w_out = 8'hFF;
    end else if (r_sh_blank_lz && w_lz[r_idx]) begin
      w_out = {7'h7F, ~r_sh_dp[r_idx]};
    end else begin
      w_out = {w_seg[7:1], w_seg[0] & ~r_sh_dp[r_idx]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prescale     <= '0;
      r_idx          <= 2'd0;
      r_frame_cnt    <= 10'd0;
      r_blink_phase  <= 1'b0;
      r_load_pending <= 1'b1;
      r_sh_digits    <= 16'd0;
      r_sh_blank_lz  <= 1'b0;
      r_sh_blink     <= 4'd0;
      r_sh_dp        <= 4'd0;
      r_ssd_ctl      <= 4'b1111;
      r_ssd_out      <= 8'hFF;
      r_frame_start  <= 1'b0;
    end else begin
      r_prescale     <= w_tick ? '0 : r_prescale + 1'b1;
      r_load_pending <= 1'b0;
      r_frame_start  <= w_load;
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
      end
      if (w_load) begin
        r_sh_digits   <= bus.digits;
        r_sh_blank_lz <= bus.blank_lz;
        r_sh_blink    <= bus.blink_mask;
        r_sh_dp       <= bus.dp_mask;
      end
      if (w_wrap) begin
        if (r_frame_cnt == c_BF_MAX) begin
          r_frame_cnt   <= 10'd0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + 10'd1;
        end
      end
      r_ssd_ctl <= ~(4'b0001 << r_idx);
      r_ssd_out <= w_out;
    end
  end

  assign bus.ssd_ctl     = r_ssd_ctl;
  assign bus.ssd_out     = r_ssd_out;
  assign bus.frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
// ----------------------------------------------------------------------------
// tb_bcd_scan_display : table-driven frame checks with an expected-frame queue
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bcd_scan_display;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_scan_display_if bus ();

  bcd_scan_display #(
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [15:0] digits;
    logic        blank_lz;
    logic [3:0]  dp_mask;
    logic [31:0] exp;      // {d3, d2, d1, d0}
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] sb [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_fs();
    int cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (bus.frame_start !== 1'b1 && cnt < 100);
    if (bus.frame_start !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_start_timeout: got %b expected 1", bus.frame_start);
    end
  endtask

  // Called at the negedge where frame_start is high; ends on the next one.
  task automatic check_frame(input bit chg, input logic [15:0] nd, input logic [31:0] nexp);
    logic [31:0] e;
    logic [3:0]  onehot;
    int          k;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (chg && i == 4) begin
        bus.digits = nd;
        sb.push_back(nexp);
      end
      k      = i / 4;
      onehot = 4'b0001 << k;
      chk("ssd_ctl", {28'd0, bus.ssd_ctl}, {28'd0, ~onehot});
      chk("ssd_out", {24'd0, bus.ssd_out}, {24'd0, e[8*k +: 8]});
      chk("frame_start", {31'd0, bus.frame_start}, {31'd0, (i == 15)});
    end
  endtask

  initial begin
    vecs[0] = '{16'h1234, 1'b0, 4'b0100, {8'h9F, 8'h24, 8'h0D, 8'h99}};
    vecs[1] = '{16'h00AF, 1'b0, 4'b0000, {8'h03, 8'h03, 8'hFD, 8'hFD}};
    vecs[2] = '{16'h0007, 1'b1, 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'h1F}};
    vecs[3] = '{16'h0000, 1'b1, 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'h03}};
    vecs[4] = '{16'h1005, 1'b1, 4'b0000, {8'h9F, 8'h03, 8'h03, 8'h49}};
    vecs[5] = '{16'h0007, 1'b1, 4'b0010, {8'hFF, 8'hFF, 8'hFE, 8'h1F}};
    vecs[6] = '{16'h0059, 1'b1, 4'b1000, {8'hFE, 8'hFF, 8'h49, 8'h09}};
    vecs[7] = '{16'h0A00, 1'b1, 4'b0000, {8'hFF, 8'hFD, 8'h03, 8'h03}};
    vecs[8] = '{16'h6789, 1'b0, 4'b1111, {8'h40, 8'h1E, 8'h00, 8'h08}};

    bus.digits     = 16'h1234;
    bus.blank_lz   = 1'b0;
    bus.blink_mask = 4'b0000;
    bus.dp_mask    = 4'b0000;

    // Reset state held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ctl", {28'd0, bus.ssd_ctl}, 32'hF);
      chk("rst_out", {24'd0, bus.ssd_out}, 32'hFF);
      chk("rst_fs", {31'd0, bus.frame_start}, 32'd0);
    end
    rst = 1'b0;

    // First scan frame: slot sequence and frame_start placement
    for (int i = 1; i <= 16; i++) begin
      logic [3:0] oh;
      @(negedge clk);
      oh = 4'b0001 << ((i - 1) / 4);
      chk("scan_ctl", {28'd0, bus.ssd_ctl}, {28'd0, ~oh});
      chk("scan_fs", {31'd0, bus.frame_start}, {31'd0, (i == 1 || i == 16)});
    end

    foreach (vecs[v]) begin
      bus.digits   = vecs[v].digits;
      bus.blank_lz = vecs[v].blank_lz;
      bus.dp_mask  = vecs[v].dp_mask;
      sb.push_back(vecs[v].exp);
      wait_fs();
      check_frame(1'b0, 16'h0, 32'h0);
    end

    // Snapshot coherence: change digits mid-frame while idx=1
    bus.digits   = 16'h0059;
    bus.blank_lz = 1'b0;
    bus.dp_mask  = 4'b0000;
    sb.push_back({8'h03, 8'h03, 8'h49, 8'h09});
    wait_fs();
    check_frame(1'b1, 16'h0100, {8'h03, 8'h9F, 8'h03, 8'h03});
    check_frame(1'b0, 16'h0, 32'h0);

    // Blink: frames counted from reset, BLINK_FRAMES=2
    @(negedge clk);
    rst            = 1'b1;
    bus.digits     = 16'h1234;
    bus.blink_mask = 4'b0011;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_fs();  // frame 0
    wait_fs();  // frame 1
    for (int f = 1; f <= 6; f++) begin
      if (((f >> 1) & 1) == 1) sb.push_back({8'h9F, 8'h25, 8'hFF, 8'hFF});
      else                     sb.push_back({8'h9F, 8'h25, 8'h0D, 8'h99});
      check_frame(1'b0, 16'h0, 32'h0);
    end

    // Frame 7 (blink phase 1): reset while idx=2
    repeat (8) @(negedge clk);
    chk("pre_rst_blink", {24'd0, bus.ssd_out}, 32'hFF);
    rst        = 1'b1;
    bus.digits = 16'h4321;
    @(negedge clk);
    chk("midrst_ctl", {28'd0, bus.ssd_ctl}, 32'hF);
    chk("midrst_out", {24'd0, bus.ssd_out}, 32'hFF);
    chk("midrst_fs", {31'd0, bus.frame_start}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_fs", {31'd0, bus.frame_start}, 32'd1);
    chk("post_rst_ctl", {28'd0, bus.ssd_ctl}, 32'hE);
    wait_fs();  // frame 1
    sb.push_back({8'h99, 8'h0D, 8'h25, 8'h9F});
    check_frame(1'b0, 16'h0, 32'h0);
    sb.push_back({8'h99, 8'h0D, 8'hFF, 8'hFF});
    check_frame(1'b0, 16'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
